// File: rtl/light_fault_monitor.sv
// light_fault_monitor: safety stage between the traffic light controller
// and the lamps. Validates the one-hot NS/EW codes every cycle, passes
// good samples through with one cycle of latency, and on any violation
// latches a fault code and flashes red in both directions until cleared.
module light_fault_monitor #(
    parameter int unsigned MIN_YELLOW = 5,
    parameter int unsigned MAX_HOLD   = 40,
    parameter int unsigned FLASH_HALF = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ns_in,
    input  logic [2:0] ew_in,
    input  logic       clear_fault,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] DARK   = 3'b000;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_INVALID  = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_TRANS    = 3'd3;
    localparam logic [2:0] CODE_SHORT    = 3'd4;
    localparam logic [2:0] CODE_STUCK    = 3'd5;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_YEL_C  = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HALF_C     = CNT_W'(FLASH_HALF);

    typedef enum logic [1:0] {
        RESYNC,
        CHECK,
        FLASH
    } state_t;

    state_t state, state_next;

    logic [2:0]       prev_ns, prev_ew;
    logic [CNT_W-1:0] hold_cnt, yel_ns, yel_ew, flash_cnt;
    logic             flash_on;

    logic [2:0]       prev_ns_d, prev_ew_d, ns_lamp_d, ew_lamp_d, fault_code_d;
    logic [CNT_W-1:0] hold_cnt_d, yel_ns_d, yel_ew_d, flash_cnt_d;
    logic             flash_on_d, fault_d;

    logic       ns_ok, ew_ok, sync_ok, changed;
    logic [2:0] code_det;

    // G->R, Y->G and R->Y skip a phase of the light cycle.
    function automatic logic bad_step(input logic [2:0] p, input logic [2:0] n);
        return (p == GREEN && n == RED) || (p == YELLOW && n == GREEN) ||
               (p == RED && n == YELLOW);
    endfunction

    function automatic logic short_yel(input logic [2:0] p, input logic [2:0] n,
                                       input logic [CNT_W-1:0] cnt);
        return (p == YELLOW) && (n == RED) && (cnt < MIN_YEL_C);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    assign ns_ok   = $onehot(ns_in);
    assign ew_ok   = $onehot(ew_in);
    assign sync_ok = ns_ok && ew_ok && (ns_in == RED || ew_in == RED);
    assign changed = ({ns_in, ew_in} != {prev_ns, prev_ew});

    // Classify the current sample; checks are ordered so the lowest code wins.
    always_comb begin
        code_det = CODE_NONE;
        if (!(ns_ok && ew_ok))
            code_det = CODE_INVALID;
        else if (ns_in != RED && ew_in != RED)
            code_det = CODE_CONFLICT;
        else if (bad_step(prev_ns, ns_in) || bad_step(prev_ew, ew_in))
            code_det = CODE_TRANS;
        else if (short_yel(prev_ns, ns_in, yel_ns) || short_yel(prev_ew, ew_in, yel_ew))
            code_det = CODE_SHORT;
        else if (!changed && hold_cnt == MAX_HOLD_C)
            code_det = CODE_STUCK;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= RESYNC;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            RESYNC:  if (sync_ok) state_next = CHECK;
            CHECK:   if (code_det != CODE_NONE) state_next = FLASH;
            FLASH:   if (clear_fault) state_next = RESYNC;
            default: state_next = RESYNC;
        endcase
    end

    // Next values of lamps, fault flags and the hold/yellow/flash counters.
    always_comb begin
        prev_ns_d    = prev_ns;
        prev_ew_d    = prev_ew;
        hold_cnt_d   = hold_cnt;
        yel_ns_d     = yel_ns;
        yel_ew_d     = yel_ew;
        flash_cnt_d  = flash_cnt;
        flash_on_d   = flash_on;
        fault_d      = fault;
        fault_code_d = fault_code;
        ns_lamp_d    = RED;
        ew_lamp_d    = RED;
        case (state)
            RESYNC: begin
                if (sync_ok) begin
                    prev_ns_d  = ns_in;
                    prev_ew_d  = ew_in;
                    ns_lamp_d  = ns_in;
                    ew_lamp_d  = ew_in;
                    hold_cnt_d = ONE;
                    yel_ns_d   = (ns_in == YELLOW) ? ONE : '0;
                    yel_ew_d   = (ew_in == YELLOW) ? ONE : '0;
                end
            end
            CHECK: begin
                if (code_det != CODE_NONE) begin
                    fault_d      = 1'b1;
                    fault_code_d = code_det;
                    flash_cnt_d  = ONE;
                    flash_on_d   = 1'b1;
                end else begin
                    prev_ns_d  = ns_in;
                    prev_ew_d  = ew_in;
                    ns_lamp_d  = ns_in;
                    ew_lamp_d  = ew_in;
                    hold_cnt_d = changed ? ONE : hold_cnt + ONE;
                    yel_ns_d   = (ns_in == YELLOW) ? sat_inc(yel_ns) : '0;
                    yel_ew_d   = (ew_in == YELLOW) ? sat_inc(yel_ew) : '0;
                end
            end
            FLASH: begin
                if (clear_fault) begin
                    fault_d      = 1'b0;
                    fault_code_d = CODE_NONE;
                    hold_cnt_d   = '0;
                    yel_ns_d     = '0;
                    yel_ew_d     = '0;
                    flash_cnt_d  = '0;
                    flash_on_d   = 1'b0;
                end else begin
                    // The counter rests at FLASH_HALF for one cycle before
                    // wrapping, giving FLASH_HALF cycles per phase.
                    if (flash_cnt == HALF_C) begin
                        flash_cnt_d = ONE;
                        flash_on_d  = ~flash_on;
                    end else begin
                        flash_cnt_d = flash_cnt + ONE;
                    end
                    ns_lamp_d = flash_on_d ? RED : DARK;
                    ew_lamp_d = flash_on_d ? RED : DARK;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ns    <= RED;
            prev_ew    <= RED;
            hold_cnt   <= '0;
            yel_ns     <= '0;
            yel_ew     <= '0;
            flash_cnt  <= '0;
            flash_on   <= 1'b0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            ns_lamp    <= RED;
            ew_lamp    <= RED;
        end else begin
            prev_ns    <= prev_ns_d;
            prev_ew    <= prev_ew_d;
            hold_cnt   <= hold_cnt_d;
            yel_ns     <= yel_ns_d;
            yel_ew     <= yel_ew_d;
            flash_cnt  <= flash_cnt_d;
            flash_on   <= flash_on_d;
            fault      <= fault_d;
            fault_code <= fault_code_d;
            ns_lamp    <= ns_lamp_d;
            ew_lamp    <= ew_lamp_d;
        end
    end

endmodule

// File: tb/tb_light_fault_monitor.sv
// Bench for light_fault_monitor: directed scenarios, a run-length based
// reference model checked every cycle, and literal spot checks.
module tb_light_fault_monitor;

    localparam int MIN_YELLOW = 5;
    localparam int MAX_HOLD   = 40;
    localparam int FLASH_HALF = 2;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] D = 3'b000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ns_in = R;
    logic [2:0] ew_in = R;
    logic       clear_fault = 1'b0;
    logic [2:0] ns_lamp, ew_lamp, fault_code;
    logic       fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    light_fault_monitor #(
        .MIN_YELLOW(MIN_YELLOW),
        .MAX_HOLD  (MAX_HOLD),
        .FLASH_HALF(FLASH_HALF),
        .CNT_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ns_in      (ns_in),
        .ew_in      (ew_in),
        .clear_fault(clear_fault),
        .ns_lamp    (ns_lamp),
        .ew_lamp    (ew_lamp),
        .fault      (fault),
        .fault_code (fault_code)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_live = 0, m_checking = 0, m_faulted = 0;
    logic [2:0] m_last_ns, m_last_ew;
    int         run_len, yrun_ns, yrun_ew, fl_age;
    logic [2:0] exp_ns = R, exp_ew = R, exp_code = 3'd0;
    logic       exp_fault = 1'b0;

    function automatic logic [2:0] succ(input logic [2:0] c);
        return (c == G) ? Y : (c == Y) ? R : G;
    endfunction

    function automatic bit legal(input logic [2:0] p, input logic [2:0] n);
        return (n == p) || (n == succ(p));
    endfunction

    function automatic int classify(input logic [2:0] n, input logic [2:0] e);
        bit same;
        same = (n == m_last_ns) && (e == m_last_ew);
        if ($countones(n) != 1 || $countones(e) != 1) return 1;
        if (n != R && e != R) return 2;
        if (!legal(m_last_ns, n) || !legal(m_last_ew, e)) return 3;
        if ((m_last_ns == Y && n == R && yrun_ns < MIN_YELLOW) ||
            (m_last_ew == Y && e == R && yrun_ew < MIN_YELLOW)) return 4;
        if (same && run_len == MAX_HOLD) return 5;
        return 0;
    endfunction

    always @(posedge clk) begin
        int code;
        if (rst) begin
            m_live = 1; m_checking = 0; m_faulted = 0;
            exp_ns = R; exp_ew = R; exp_fault = 0; exp_code = 0;
        end else if (m_live) begin
            if (m_faulted) begin
                if (clear_fault) begin
                    m_faulted = 0; m_checking = 0;
                    exp_fault = 0; exp_code = 0; exp_ns = R; exp_ew = R;
                end else begin
                    fl_age++;
                    exp_ns = ((fl_age / FLASH_HALF) % 2 == 0) ? R : D;
                    exp_ew = exp_ns;
                end
            end else if (!m_checking) begin
                exp_ns = R; exp_ew = R;
                if ($countones(ns_in) == 1 && $countones(ew_in) == 1 &&
                    (ns_in == R || ew_in == R)) begin
                    m_checking = 1;
                    exp_ns = ns_in; exp_ew = ew_in;
                    m_last_ns = ns_in; m_last_ew = ew_in;
                    run_len = 1;
                    yrun_ns = (ns_in == Y) ? 1 : 0;
                    yrun_ew = (ew_in == Y) ? 1 : 0;
                end
            end else begin
                code = classify(ns_in, ew_in);
                if (code != 0) begin
                    m_faulted = 1; fl_age = 0;
                    exp_fault = 1; exp_code = 3'(code); exp_ns = R; exp_ew = R;
                end else begin
                    run_len = (ns_in == m_last_ns && ew_in == m_last_ew) ? run_len + 1 : 1;
                    yrun_ns = (ns_in == Y) ? yrun_ns + 1 : 0;
                    yrun_ew = (ew_in == Y) ? yrun_ew + 1 : 0;
                    m_last_ns = ns_in; m_last_ew = ew_in;
                    exp_ns = ns_in; exp_ew = ew_in;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("ns_lamp", 32'(ns_lamp), 32'(exp_ns));
            chk("ew_lamp", 32'(ew_lamp), 32'(exp_ew));
            chk("fault", 32'(fault), 32'(exp_fault));
            chk("fault_code", 32'(fault_code), 32'(exp_code));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [2:0] n, input logic [2:0] e, input logic c);
        ns_in = n; ew_in = e; clear_fault = c;
        @(posedge clk); #1;
    endtask

    task automatic lit(input string name, input logic [2:0] n, input logic [2:0] e,
                       input logic f, input logic [2:0] code);
        chk({name, "_ns"}, 32'(ns_lamp), 32'(n));
        chk({name, "_ew"}, 32'(ew_lamp), 32'(e));
        chk({name, "_fault"}, 32'(fault), 32'(f));
        chk({name, "_code"}, 32'(fault_code), 32'(code));
    endtask

    initial begin
        int p;
        // Reset
        rst = 1;
        step(G, G, 1'b0);
        step(G, R, 1'b1);
        lit("reset", R, R, 1'b0, 3'd0);
        rst = 0;

        // Normal operation: two full controller periods
        for (int t = 0; t < 148; t++) begin
            p = t % 74;
            if (p < 31)      step(G, R, 1'b0);
            else if (p < 37) step(Y, R, 1'b0);
            else if (p < 68) step(R, G, 1'b0);
            else             step(R, Y, 1'b0);
            if (t == 0)  lit("first_pass", G, R, 1'b0, 3'd0);
            if (t == 36) lit("ns_yellow_end", Y, R, 1'b0, 3'd0);
            if (t == 37) lit("ew_green", R, G, 1'b0, 3'd0);
        end

        // Conflict (EW Y->G also illegal, conflict must win)
        step(G, G, 1'b0);
        lit("conflict", R, R, 1'b1, 3'd2);
        step(G, R, 1'b0);
        lit("flash_age1", R, R, 1'b1, 3'd2);
        step(G, R, 1'b0);
        lit("flash_dark", D, D, 1'b1, 3'd2);
        step(G, R, 1'b0);
        step(G, R, 1'b0);
        lit("flash_red_again", R, R, 1'b1, 3'd2);
        step(R, R, 1'b1);
        lit("clear1", R, R, 1'b0, 3'd0);

        // Illegal transition G->R
        for (int i = 0; i < 10; i++) step(G, R, 1'b0);
        step(R, R, 1'b0);
        lit("illegal", R, R, 1'b1, 3'd3);
        step(R, R, 1'b1);

        // Short yellow
        for (int i = 0; i < 5; i++) step(G, R, 1'b0);
        for (int i = 0; i < 3; i++) step(Y, R, 1'b0);
        step(R, R, 1'b0);
        lit("short_yellow", R, R, 1'b1, 3'd4);
        step(R, R, 1'b1);

        // Stuck, after reset and a (ignored) clear in RESYNC
        rst = 1;
        step(R, R, 1'b0);
        rst = 0;
        step(D, R, 1'b1);
        lit("resync_clear", R, R, 1'b0, 3'd0);
        for (int i = 0; i < 40; i++) step(G, R, 1'b0);
        lit("hold40", G, R, 1'b0, 3'd0);
        step(G, R, 1'b0);
        lit("stuck", R, R, 1'b1, 3'd5);

        // Priority and recovery
        step(R, R, 1'b1);
        step(G, R, 1'b0);
        step(3'b011, G, 1'b0);
        lit("priority", R, R, 1'b1, 3'd1);
        step(R, R, 1'b1);
        lit("recover", R, R, 1'b0, 3'd0);
        step(G, G, 1'b0);
        lit("resync_ignore", R, R, 1'b0, 3'd0);
        step(G, R, 1'b0);
        lit("resume", G, R, 1'b0, 3'd0);
        step(Y, R, 1'b1);
        lit("clear_in_check", Y, R, 1'b0, 3'd0);

        // Reset mid-flash (Y->R after one yellow cycle)
        step(R, R, 1'b0);
        lit("short_yel2", R, R, 1'b1, 3'd4);
        step(R, R, 1'b0);
        step(R, R, 1'b0);
        lit("dark_before_rst", D, D, 1'b1, 3'd4);
        rst = 1;
        step(R, R, 1'b0);
        lit("rst_mid_flash", R, R, 1'b0, 3'd0);
        rst = 0;
        step(G, G, 1'b0);
        lit("post_rst_resync", R, R, 1'b0, 3'd0);
        step(R, G, 1'b0);
        lit("post_rst_check", R, G, 1'b0, 3'd0);
        step(R, G, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/light_fault_monitor.md
# light_fault_monitor

Safety stage directly downstream of the traffic light controller. Samples the controller's one-hot NS/EW light codes every cycle, checks them for invalid codes, conflicting greens, illegal sequences, short yellows and stuck patterns, and drives the lamp outputs. On any violation it latches a fault code and forces both directions to flashing red until software clears it.

## Interface
- MIN_YELLOW, 5: minimum legal yellow duration in cycles.
- MAX_HOLD, 40: maximum cycles a {ns,ew} pattern may stay unchanged.
- FLASH_HALF, 2: cycles per flash half-period (lamps on, then off).
- CNT_W, 8: width of the hold, yellow and flash counters. Must hold MAX_HOLD and FLASH_HALF.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ns_in  in  3  NS code from controller: 001 green, 010 yellow, 100 red
- ew_in  in  3  EW code, same encoding
- clear_fault  in  1  single-cycle request to leave flashing mode
- ns_lamp  out  3  registered NS lamp drive, same encoding, 000 = dark
- ew_lamp  out  3  registered EW lamp drive
- fault  out  1  registered, high while a fault is latched
- fault_code  out  3  registered cause: 0 none, 1 invalid code, 2 conflict, 3 illegal transition, 4 short yellow, 5 stuck

## Operation
- States: RESYNC, CHECK, FLASH. Reset goes to RESYNC with ns_lamp=ew_lamp=100, fault=0, fault_code=0, all counters 0.
- **RESYNC**
  - Lamps held at 100/100.
  - Moves to CHECK at the first edge where both inputs are one-hot and at least one is red.
  - On that edge: prev_ns/prev_ew <= inputs, lamps <= inputs, hold_cnt <= 1, per-direction yel_cnt <= 1 if that input is yellow, else 0.
  - Invalid or conflicting samples in RESYNC do not raise a fault.
- **CHECK**, per sample:
  - (1) Invalid: either input not exactly one-hot.
  - (2) Conflict: neither input is red.
  - (3) Illegal transition in either direction. Legal: G->G, G->Y, Y->Y, Y->R, R->R, R->G. Illegal: G->R, Y->G, R->Y.
  - (4) Short yellow: a direction goes Y->R with its yel_cnt < MIN_YELLOW.
  - (5) Stuck: the pair is unchanged from prev and hold_cnt == MAX_HOLD.
- Fault priority when several hold in one cycle: lowest code wins.
- No fault in CHECK:
  - Lamps <= inputs and prev <= inputs.
  - hold_cnt <= 1 on any change, else hold_cnt+1.
  - yel_cnt <= yel_cnt+1 while yellow, else 0.
- Fault detected in CHECK, on the same edge:
  - State goes to FLASH; fault <= 1; fault_code <= code.
  - Lamps <= 100/100.
  - flash_cnt <= 1, phase <= on.
  - The offending sample never reaches the lamps.
- **FLASH**
  - flash_cnt increments each cycle. When it reaches FLASH_HALF it wraps to 1 and phase toggles.
  - Lamps are 100/100 in the on phase and 000/000 in the off phase.
  - Inputs are ignored.
- **clear_fault** in FLASH: on that edge, next state is RESYNC, fault <= 0, fault_code <= 0, lamps <= 100/100. clear_fault is ignored in RESYNC and CHECK.
- Reset in any state, including mid-flash, returns to the reset values above.

## Timing
- CHECK pass-through latency is 1 cycle: input at edge N appears on the lamps after edge N.
- fault and fault_code rise on the edge that samples the violation. The lamps show red in that same cycle.
- Flash pattern after a fault edge with FLASH_HALF=2: 2 cycles red, 2 cycles dark, repeating.
- Leaving RESYNC takes at least 1 cycle after reset or clear.
- With a normal controller (green 31 cycles, yellow 6 cycles, 74-cycle period), the defaults never fault.

## Test plan
- Normal operation: reset, then drive the controller sequence for 2 full periods (148 cycles). Required: lamps equal the inputs delayed 1 cycle, fault=0 throughout.
- Conflict: in CHECK, force ns=001, ew=001. Required: next cycle fault=1, fault_code=2, lamps 100/100, then 2 dark / 2 red alternating.
- Illegal transition: NS green for 10 cycles, then NS red directly. Required: fault_code=3; the red-without-yellow sample is not passed through to the lamps.
- Short yellow and stuck:
  - NS yellow for 3 cycles, then red. Required: fault_code=4.
  - Separately, after reset and clear, hold 001/100 for 41 cycles. Required: fault_code=5 on the 41st sample.
- Priority and recovery: ns=011 with ew=001 in the same cycle. Required: fault_code=1 (not 2). Then pulse clear_fault. Required: fault=0 next cycle, lamps 100/100 in RESYNC, CHECK resumes on the first valid sample.
- Reset mid-flash: assert rst during the dark phase. Required: next cycle lamps 100/100, fault=0, fault_code=0, state RESYNC.
